// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

   localparam int unsigned DIV_W = 32;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StIter,
      StFix,
      StDone
   } div_state_e;

   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not go negative.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic [WIDTH-1:0] prem_i,
   input  logic             q_msb_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] prem_o,
   output logic             q_bit_o
);

   // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
   logic [WIDTH:0] shifted;
   logic           keep;

   always_comb begin
      shifted = {prem_i, q_msb_i};
      keep    = (shifted >= {1'b0, dvs_i});
      q_bit_o = keep;
      prem_o  = keep ? WIDTH'(shifted - {1'b0, dvs_i}) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_BYZERO_EN: short-cut zero divisors and report them on div0.
module div_iter
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
`ifdef DIV_BYZERO_EN
   ,
   output logic             div0
`endif
);

   localparam int unsigned CntW = cnt_w(WIDTH);

   div_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;  // raw dividend, then magnitude shifting into quotient
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             sign_q, sign_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
`ifdef DIV_BYZERO_EN
   logic             zero_q, zero_d;
   logic             div0_q, div0_d;
`endif

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .prem_i  (prem_q),
      .q_msb_i (a_q[WIDTH-1]),
      .dvs_i   (b_q),
      .prem_o  (step_rem),
      .q_bit_o (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      prem_d  = prem_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      sign_d  = sign_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
`ifdef DIV_BYZERO_EN
      zero_d  = zero_q;
      div0_d  = div0_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sign_d  = sign;
               state_d = StPrep;
            end
         end
         StPrep: begin
            qneg_d  = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg_d  = sign_q & a_q[WIDTH-1];
            a_d     = (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
            b_d     = (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = StIter;
`ifdef DIV_BYZERO_EN
            zero_d = (b_q == '0);
            // Zero divisor skips the iterations and keeps the raw dividend for rem.
            if (b_q == '0) begin
               a_d     = a_q;
               state_d = StFix;
            end
`endif
         end
         StIter: begin
            prem_d = step_rem;
            a_d    = {a_q[WIDTH-2:0], step_q};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            quot_d  = qneg_q ? -a_q : a_q;
            rem_d   = rneg_q ? -prem_q : prem_q;
            done_d  = 1'b1;
            state_d = StDone;
`ifdef DIV_BYZERO_EN
            div0_d = zero_q;
            if (zero_q) begin
               quot_d = '1;
               rem_d  = a_q;
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Flush wins over everything: results stay as they were before this operation.
      if (cancel) begin
         state_d = StIdle;
         done_d  = 1'b0;
         quot_d  = quot_q;
         rem_d   = rem_q;
`ifdef DIV_BYZERO_EN
         div0_d  = div0_q;
`endif
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prem_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         sign_q  <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DIV_BYZERO_EN
         zero_q  <= 1'b0;
         div0_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prem_q  <= prem_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         sign_q  <= sign_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DIV_BYZERO_EN
         zero_q  <= zero_d;
         div0_q  <= div0_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;
`ifdef DIV_BYZERO_EN
   assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: expected results queued at issue, popped and compared on done.
module tb_div_iter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start, sign, cancel;
   logic [W-1:0]  a, b;
   logic          busy, done;
   logic [W-1:0]  quot, rem;
`ifdef DIV_BYZERO_EN
   logic          div0;
`endif

   div_iter #(
      .WIDTH (W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sign   (sign),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .quot   (quot),
      .rem    (rem)
`ifdef DIV_BYZERO_EN
      ,
      .div0   (div0)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      logic [7:0]   lat;
   } exp_t;

   exp_t         sb[$];
   int           n_chk  = 0;
   int           n_pass = 0;
   int           n_fail = 0;
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: divide magnitudes with the language operators, then apply MIPS sign rules.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W-1:0] mx, my, q, r;
      exp_t         e;
      mx    = (s && x[W-1]) ? -x : x;
      my    = (s && y[W-1]) ? -y : y;
      q     = (my == '0) ? '1 : mx / my;
      r     = (my == '0) ? mx : mx % my;
      e.q   = (s && (x[W-1] ^ y[W-1])) ? -q : q;
      e.r   = (s && x[W-1]) ? -r : r;
      e.z   = 1'b0;
      e.lat = 8'(W + 2);
`ifdef DIV_BYZERO_EN
      if (y == '0) begin
         e.q   = '1;
         e.r   = x;
         e.z   = 1'b1;
         e.lat = 8'd2;
      end
`endif
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input string tag);
      exp_t e;
      int   n;
      logic busy_bad;
      sb.push_back(model(x, y, s));
      a = x; b = y; sign = s; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      busy_bad = 1'b0;
      while (!done && n < 100) begin
         if (!busy) busy_bad = 1'b1;
         // A start while busy must be dropped.
         if (n == 5) begin
            start = 1'b1; a = 32'd9; b = 32'd3;
         end
         tick();
         start = 1'b0;
         n++;
      end
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(n), 32'(e.lat));
      check({tag, "_busy_hold"}, {31'd0, busy_bad}, '0);
      check({tag, "_quot"}, quot, e.q);
      check({tag, "_rem"}, rem, e.r);
`ifdef DIV_BYZERO_EN
      check({tag, "_div0"}, {31'd0, div0}, {31'd0, e.z});
`endif
      // Start during the done cycle is ignored as well.
      start = 1'b1; a = 32'd8; b = 32'd2; sign = 1'b0;
      tick();
      start = 1'b0;
      check({tag, "_idle_after_done"}, {31'd0, busy}, '0);
      check({tag, "_quot_held"}, quot, e.q);
      last_q = e.q;
      last_r = e.r;
   endtask

   initial begin
      logic          seen;
      logic [W-1:0]  x, y;
      rst = 1'b1; start = 1'b0; sign = 1'b0; cancel = 1'b0; a = '0; b = '0;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, '0);
      check("rst_done", {31'd0, done}, '0);
      check("rst_quot", quot, '0);
      check("rst_rem", rem, '0);
      rst = 1'b0;
      tick();

      run_op(32'd100, 32'd7, 1'b0, "divu_100_7");
      run_op(-32'd7, 32'd2, 1'b1, "div_m7_2");
      check("div_m7_2_lit_q", last_q, 32'hFFFF_FFFD);
      check("div_m7_2_lit_r", last_r, 32'hFFFF_FFFF);
      run_op(32'd7, -32'd2, 1'b1, "div_7_m2");
      check("div_7_m2_lit_q", last_q, 32'hFFFF_FFFD);
      check("div_7_m2_lit_r", last_r, 32'd1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
      check("div_ovf_lit_q", last_q, 32'h8000_0000);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
      run_op(32'd5, 32'd0, 1'b0, "divu_5_0");
      check("divu_5_0_lit_q", last_q, 32'hFFFF_FFFF);
      check("divu_5_0_lit_r", last_r, 32'd5);

      // Cancel partway through the iterations.
      a = 32'd20; b = 32'd4; sign = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel_busy", {31'd0, busy}, '0);
      check("cancel_done", {31'd0, done}, '0);
      check("cancel_quot", quot, last_q);
      check("cancel_rem", rem, last_r);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("cancel_no_done", {31'd0, seen}, '0);
      run_op(32'd20, 32'd4, 1'b0, "divu_20_4");

      // Cancel beats start in IDLE.
      a = 32'd30; b = 32'd3; start = 1'b1; cancel = 1'b1;
      tick();
      start = 1'b0; cancel = 1'b0;
      check("cancel_beats_start", {31'd0, busy}, '0);

      for (int i = 0; i < 4; i++) begin
         x = $urandom;
         y = $urandom_range(1, 5000);
         if (i[1]) y = -y;
         run_op(x, y, i[0], "rand");
      end

      // Reset in the middle of the iterations.
      a = 32'd1000; b = 32'd3; sign = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", {31'd0, busy}, '0);
      check("midrst_done", {31'd0, done}, '0);
      check("midrst_quot", quot, '0);
      check("midrst_rem", rem, '0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("midrst_no_done", {31'd0, seen}, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
